// File: rtl/crc_16_check_pkg.sv
// Shared sideband CRC-16 definitions: polynomial, seed, symbol framing and checker FSM states.
package crc_16_check_pkg;

   localparam int unsigned CRC_W     = 16;
   localparam int unsigned SYM_BITS  = 10;
   localparam int unsigned START_POS = 0;
   localparam int unsigned STOP_POS  = SYM_BITS - 1;
   localparam int unsigned POS_W     = 4;

   localparam logic [CRC_W-1:0] CRC16_POLY = 16'h8005;
   localparam logic [CRC_W-1:0] CRC16_SEED = 16'hFFFF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DATA,
      ST_CHECK,
      ST_DONE,
      ST_WAIT
   } crc_state_e;

   // One serial CRC step, MSB-first, feedback from the bit falling off the top.
   function automatic logic [CRC_W-1:0] crc16_step(input logic [CRC_W-1:0] lfsr, input logic din);
      logic fb;
      fb = din ^ lfsr[CRC_W-1];
      return {lfsr[CRC_W-2:0], 1'b0} ^ (fb ? CRC16_POLY : '0);
   endfunction

endpackage

// File: rtl/crc_16_check_if.sv
// Sideband receive CRC-check bundle; master drives the line, slave is the checker.
// Optional crc_syndrome exists only with CRC_16_CHECK_SYNDROME_EN defined.
interface crc_16_check_if;
   import crc_16_check_pkg::*;

   logic             rec_ser;
   logic             crc_en;
   logic             crc_active;
   logic             crc_done;
   logic             crc_err;
   logic             frame_err;
`ifdef CRC_16_CHECK_SYNDROME_EN
   logic [CRC_W-1:0] crc_syndrome;
`endif

   modport master (
      output rec_ser, crc_en, crc_active,
      input  crc_done, crc_err, frame_err
`ifdef CRC_16_CHECK_SYNDROME_EN
      , input crc_syndrome
`endif
   );

   modport slave (
      input  rec_ser, crc_en, crc_active,
      output crc_done, crc_err, frame_err
`ifdef CRC_16_CHECK_SYNDROME_EN
      , output crc_syndrome
`endif
   );

endinterface

// File: rtl/crc_16_check_sb_sym_counter.sv
// Sideband symbol position counter (0..9) plus stop-bit symbol counter, with position strobes.
module crc_16_check_sb_sym_counter
   import crc_16_check_pkg::*;
#(
   parameter int unsigned SYM_CNT_W = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clr,
   input  logic                 en,
   input  logic                 sym_en,
   output logic [SYM_CNT_W-1:0] sym_cnt,
   output logic                 start_stb_c,
   output logic                 data_stb_c,
   output logic                 stop_stb_c
);

   logic [POS_W-1:0]     pos_q, pos_d;
   logic [SYM_CNT_W-1:0] sym_q, sym_d;

   assign start_stb_c = (pos_q == POS_W'(START_POS));
   assign stop_stb_c  = (pos_q == POS_W'(STOP_POS));
   assign data_stb_c  = !start_stb_c && !stop_stb_c;
   assign sym_cnt     = sym_q;

   // Position wraps at the stop bit; symbols are only counted when sym_en is set.
   always_comb begin
      pos_d = pos_q;
      sym_d = sym_q;
      if (clr) begin
         pos_d = '0;
         sym_d = '0;
      end else if (en) begin
         if (stop_stb_c) begin
            pos_d = '0;
            if (sym_en) sym_d = sym_q + SYM_CNT_W'(1);
         end else begin
            pos_d = pos_q + POS_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pos_q <= '0;
         sym_q <= '0;
      end else begin
         pos_q <= pos_d;
         sym_q <= sym_d;
      end
   end

endmodule

// File: rtl/crc_16_check.sv
// Receive-side CRC-16 checker for the sideband link, with start/stop framing check.
// Optional CRC_16_CHECK_SYNDROME_EN adds a held received-XOR-computed syndrome output.
module crc_16_check
   import crc_16_check_pkg::*;
#(
   parameter logic [CRC_W-1:0] SEED     = CRC16_SEED,
   parameter int unsigned      CRC_SYMS = 2
) (
   input  logic           sb_clk,
   input  logic           rst,
   crc_16_check_if.slave  sb
);

   localparam int unsigned SYM_CNT_W = (CRC_SYMS < 2) ? 1 : $clog2(CRC_SYMS + 1);

   crc_state_e       state_q, state_d;
   logic [CRC_W-1:0] lfsr_q, lfsr_d;
   logic             mismatch_q, mismatch_d;
   logic             crc_done_q, crc_done_d;
   logic             crc_err_q, crc_err_d;
   logic             frame_err_q, frame_err_d;
`ifdef CRC_16_CHECK_SYNDROME_EN
   logic [CRC_W-1:0] syn_sh_q, syn_sh_d;
   logic [CRC_W-1:0] syn_q, syn_d;
`endif

   logic [SYM_CNT_W-1:0] sym_cnt;
   logic                 start_stb_c, data_stb_c, stop_stb_c;
   logic                 frame_bad_c, last_sym_c;

   crc_16_check_sb_sym_counter #(
      .SYM_CNT_W (SYM_CNT_W)
   ) u_sym_cnt (
      .clk         (sb_clk),
      .rst_n       (rst),
      .clr         (!sb.crc_en),
      .en          (sb.crc_en),
      .sym_en      (state_q == ST_CHECK),
      .sym_cnt     (sym_cnt),
      .start_stb_c (start_stb_c),
      .data_stb_c  (data_stb_c),
      .stop_stb_c  (stop_stb_c)
   );

   assign frame_bad_c = (start_stb_c && sb.rec_ser) || (stop_stb_c && !sb.rec_ser);
   assign last_sym_c  = (sym_cnt == SYM_CNT_W'(CRC_SYMS - 1));

   // The start bit of the first symbol is consumed in IDLE, so the transaction begins there.
   always_comb begin
      state_d     = state_q;
      lfsr_d      = lfsr_q;
      mismatch_d  = mismatch_q;
      crc_done_d  = 1'b0;
      crc_err_d   = crc_err_q;
      frame_err_d = frame_err_q;
`ifdef CRC_16_CHECK_SYNDROME_EN
      syn_sh_d    = syn_sh_q;
      syn_d       = syn_q;
`endif
      if (!sb.crc_en) begin
         state_d = ST_IDLE;
         lfsr_d  = SEED;
      end else begin
         case (state_q)
            ST_IDLE: begin
               lfsr_d      = SEED;
               mismatch_d  = 1'b0;
               crc_err_d   = 1'b0;
               frame_err_d = frame_bad_c;
`ifdef CRC_16_CHECK_SYNDROME_EN
               syn_sh_d    = '0;
               syn_d       = '0;
`endif
               state_d     = sb.crc_active ? ST_CHECK : ST_DATA;
            end
            ST_DATA: begin
               if (frame_bad_c) frame_err_d = 1'b1;
               if (data_stb_c) lfsr_d = crc16_step(lfsr_q, sb.rec_ser);
               if (start_stb_c && sb.crc_active) state_d = ST_CHECK;
            end
            ST_CHECK: begin
               if (frame_bad_c) frame_err_d = 1'b1;
               if (data_stb_c) begin
                  if (sb.rec_ser != lfsr_q[CRC_W-1]) mismatch_d = 1'b1;
`ifdef CRC_16_CHECK_SYNDROME_EN
                  syn_sh_d = {syn_sh_q[CRC_W-2:0], sb.rec_ser ^ lfsr_q[CRC_W-1]};
`endif
                  lfsr_d = {lfsr_q[CRC_W-2:0], 1'b0};
               end
               if (stop_stb_c && last_sym_c) begin
                  state_d    = ST_DONE;
                  crc_done_d = 1'b1;
                  crc_err_d  = mismatch_q;
`ifdef CRC_16_CHECK_SYNDROME_EN
                  syn_d      = syn_sh_q;
`endif
               end
            end
            ST_DONE: state_d = ST_WAIT;
            ST_WAIT: state_d = ST_WAIT;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge sb_clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         lfsr_q      <= SEED;
         mismatch_q  <= 1'b0;
         crc_done_q  <= 1'b0;
         crc_err_q   <= 1'b0;
         frame_err_q <= 1'b0;
`ifdef CRC_16_CHECK_SYNDROME_EN
         syn_sh_q    <= '0;
         syn_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         lfsr_q      <= lfsr_d;
         mismatch_q  <= mismatch_d;
         crc_done_q  <= crc_done_d;
         crc_err_q   <= crc_err_d;
         frame_err_q <= frame_err_d;
`ifdef CRC_16_CHECK_SYNDROME_EN
         syn_sh_q    <= syn_sh_d;
         syn_q       <= syn_d;
`endif
      end
   end

   assign sb.crc_done  = crc_done_q;
   assign sb.crc_err   = crc_err_q;
   assign sb.frame_err = frame_err_q;
`ifdef CRC_16_CHECK_SYNDROME_EN
   assign sb.crc_syndrome = syn_q;
`endif

endmodule

// File: tb/tb_crc_16_check.sv
// Scoreboard bench for crc_16_check: expected results queued per transaction, popped on crc_done.
module tb_crc_16_check;

   typedef logic [7:0] byte_q_t[$];

   typedef struct {
      int unsigned exp_cyc;
      logic        err;
      logic        frm;
      logic [15:0] syn;
   } exp_t;

   logic        sb_clk = 1'b0;
   logic        rst;
   int unsigned cyc    = 0;
   int          n_cmp  = 0;
   int          n_mis  = 0;
   exp_t        sb_q[$];

   always #5 sb_clk = ~sb_clk;
   always @(posedge sb_clk) cyc <= cyc + 1;

   crc_16_check_if sb ();

   crc_16_check dut (
      .sb_clk (sb_clk),
      .rst    (rst),
      .sb     (sb)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference CRC: MSB-first serial CRC-16, poly 0x8005, seed 0xFFFF, line order bit7 first.
   function automatic logic [15:0] crc_model(input byte_q_t pl);
      logic [15:0] r;
      logic        fb;
      r = 16'hFFFF;
      foreach (pl[k]) begin
         for (int b = 7; b >= 0; b--) begin
            fb = pl[k][b] ^ r[15];
            r  = {r[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
         end
      end
      return r;
   endfunction

   task automatic drive_bit(input logic b, input logic act);
      @(negedge sb_clk);
      sb.crc_en     = 1'b1;
      sb.rec_ser    = b;
      sb.crc_active = act;
   endtask

   task automatic drive_sym(input logic [7:0] d, input logic act, input logic stop_b);
      drive_bit(1'b0, act);
      for (int i = 7; i >= 0; i--) drive_bit(d[i], act);
      drive_bit(stop_b, act);
   endtask

   task automatic go_idle(input int n);
      @(negedge sb_clk);
      sb.crc_en     = 1'b0;
      sb.crc_active = 1'b0;
      sb.rec_ser    = 1'b1;
      repeat (n) @(negedge sb_clk);
   endtask

   // bad_stop: index of payload symbol sent with a 0 stop bit (-1 for none).
   task automatic run_txn(input byte_q_t pl, input logic [15:0] tx_crc, input int bad_stop, input int extra);
      logic [15:0] good;
      exp_t        e;
      good = crc_model(pl);
      foreach (pl[i]) begin
         drive_sym(pl[i], 1'b0, (i == bad_stop) ? 1'b0 : 1'b1);
         if (i == 0) check_val("frame_clr_at_start", 32'(sb.frame_err), 32'd0);
      end
      drive_sym(tx_crc[15:8], 1'b1, 1'b1);
      drive_sym(tx_crc[7:0], 1'b1, 1'b1);
      e.exp_cyc = cyc + 1;
      e.err     = (tx_crc != good);
      e.frm     = (bad_stop >= 0);
      e.syn     = tx_crc ^ good;
      sb_q.push_back(e);
      for (int x = 0; x < extra; x++) drive_sym(8'hA5, 1'b1, 1'b1);
      go_idle(4);
      check_val("done_seen", 32'(sb_q.size()), 32'd0);
      check_val("crc_err_hold", 32'(sb.crc_err), 32'(e.err));
      check_val("frame_err_hold", 32'(sb.frame_err), 32'(e.frm));
`ifdef CRC_16_CHECK_SYNDROME_EN
      check_val("syndrome_hold", 32'(sb.crc_syndrome), 32'(e.syn));
`endif
   endtask

   // Scoreboard consumer: every crc_done pulse must match the oldest pending transaction.
   always @(negedge sb_clk) begin
      exp_t e;
      if (rst === 1'b1 && sb.crc_done !== 1'b0) begin
         if (sb_q.size() == 0) begin
            check_val("unexpected_done", 32'(sb.crc_done), 32'd0);
         end else begin
            e = sb_q.pop_front();
            check_val("done_cycle", cyc, e.exp_cyc);
            check_val("crc_err", 32'(sb.crc_err), 32'(e.err));
            check_val("frame_err", 32'(sb.frame_err), 32'(e.frm));
`ifdef CRC_16_CHECK_SYNDROME_EN
            check_val("syndrome", 32'(sb.crc_syndrome), 32'(e.syn));
`endif
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      byte_q_t     pl;
      logic [15:0] c;
      rst           = 1'b0;
      sb.crc_en     = 1'b0;
      sb.crc_active = 1'b0;
      sb.rec_ser    = 1'b1;
      repeat (2) @(negedge sb_clk);
      check_val("rst_done", 32'(sb.crc_done), 32'd0);
      check_val("rst_err", 32'(sb.crc_err), 32'd0);
      check_val("rst_frame", 32'(sb.frame_err), 32'd0);
      rst = 1'b1;
      repeat (2) @(negedge sb_clk);

      // Clean 0x00 payload, then LSB of CRC flipped with a trailing ignored symbol.
      pl = {8'h00};
      run_txn(pl, 16'hFD02, -1, 0);
      run_txn(pl, 16'hFD03, -1, 1);

      // Bad payload stop bit, then a clean transaction must clear the flag.
      run_txn(pl, 16'hFD02, 0, 0);
      run_txn(pl, 16'hFD02, -1, 0);

      // Abort after 5 CHECK cycles: no done pulse, next transaction clean.
      drive_sym(8'h00, 1'b0, 1'b1);
      drive_bit(1'b0, 1'b1);
      for (int i = 0; i < 4; i++) drive_bit(1'b1, 1'b1);
      go_idle(30);
      check_val("abort_no_done", 32'(sb.crc_done), 32'd0);
      run_txn(pl, 16'hFD02, -1, 0);

      // Reset mid-DATA after a bad start bit.
      drive_bit(1'b1, 1'b0);
      for (int i = 0; i < 3; i++) drive_bit(1'b0, 1'b0);
      @(negedge sb_clk);
      check_val("frame_pre_rst", 32'(sb.frame_err), 32'd1);
      #2 rst = 1'b0;
      #1;
      check_val("mid_rst_frame", 32'(sb.frame_err), 32'd0);
      check_val("mid_rst_err", 32'(sb.crc_err), 32'd0);
      check_val("mid_rst_done", 32'(sb.crc_done), 32'd0);
      check_val("mid_rst_lfsr", 32'(dut.lfsr_q), 32'h0000_FFFF);
      sb.crc_en     = 1'b0;
      sb.crc_active = 1'b0;
      sb.rec_ser    = 1'b1;
      repeat (2) @(negedge sb_clk);
      rst = 1'b1;
      repeat (2) @(negedge sb_clk);
      run_txn(pl, 16'hFD02, -1, 0);

      // Zero-length payload: CRC checked against the seed.
      pl = {};
      run_txn(pl, 16'hFFFF, -1, 0);

      // Random payloads: correct CRC, then a single flipped CRC bit.
      for (int t = 0; t < 4; t++) begin
         pl = {};
         for (int k = 0; k < int'($urandom_range(4, 1)); k++) pl.push_back(8'($urandom));
         c = crc_model(pl);
         if (t[0]) c = c ^ (16'h0001 << $urandom_range(15, 0));
         run_txn(pl, c, -1, 0);
      end

      check_val("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/crc_16_check.md
Name: crc_16_check

Overview:
Receive-side CRC-16 checker for the sideband link. It takes the serial line bit by bit, rebuilds the 10-bit symbol framing (start bit, 8 data bits, stop bit) and runs the CRC over the payload data bits. It then compares the two received CRC symbols, MSB first, against the locally computed remainder. It sits behind the sideband deserializer and flags CRC and framing errors to the receive transaction FSM.

Parameters:
SEED, 16'hFFFF, LFSR initial value, loaded at reset and whenever crc_en is low.
CRC_SYMS, 2, number of 10-bit CRC symbols that follow the payload.

Ports:
sb_clk  input  1  module clock, one line bit per cycle.
rst  input  1  asynchronous active-low reset.
rec_ser  input  1  received serial line bit, sampled on every sb_clk rising edge.
crc_en  input  1  high for the whole receive transaction (payload plus CRC symbols); low otherwise.
crc_active  input  1  high while the CRC symbols are on the line; low during the payload.
crc_done  output  1  one-cycle pulse when the last CRC bit has been checked.
crc_err  output  1  result flag: 1 = CRC mismatch; valid with crc_done and held until the next transaction starts.
frame_err  output  1  sticky flag: a start bit was not 0 or a stop bit was not 1; cleared at the next transaction start.

Behaviour:
- Reset (rst=0): lfsr=SEED, bit counter=0, symbol counter=0, state=IDLE, crc_done=0, crc_err=0, frame_err=0.
- Bit counter 0..9 advances every cycle while crc_en=1 and wraps 9->0. Position 0 is the start bit, 1..8 are data, 9 is the stop bit.
- LFSR update: next = (lfsr<<1) ^ (fb ? 16'h8005 : 0), with fb = rec_ser ^ lfsr[15]. It updates only at counter positions 1..8.
- FSM states:
  - IDLE: entered while crc_en=0. lfsr=SEED, both counters cleared. On crc_en rising, clear crc_err and frame_err, then go to DATA.
  - DATA: crc_en=1 and crc_active=0. At positions 1..8, apply the LFSR update.
  - DATA -> CHECK: when crc_active rises. crc_active changes only at symbol boundaries (counter=0).
  - CHECK: at positions 1..8, compare rec_ser with lfsr[15]. Any inequality sets the internal mismatch bit. Then lfsr shifts left, inserting 0 (no feedback).
  - CHECK symbol count: increment at position 9. After CRC_SYMS symbols, go to DONE.
  - DONE: one cycle. crc_done=1 and crc_err=mismatch. Then go to WAIT.
  - WAIT: hold until crc_en=0, then go to IDLE. Extra symbols are ignored.
- Framing, in DATA and CHECK: rec_ser=1 at position 0 or rec_ser=0 at position 9 sets frame_err. frame_err does not affect crc_err.
- Latency: crc_done is asserted on the cycle after the stop bit of the last CRC symbol is sampled.
- Abort: crc_en falling in DATA or CHECK returns to IDLE. No crc_done pulse; lfsr reloads SEED; flags keep their values until the next transaction start.
- crc_en low and crc_active high at the same time: crc_en wins (IDLE).
- Reset mid-transaction: immediate return to the reset state.
- Zero-length payload (crc_active already high at crc_en rise): CRC is checked against SEED.

Optional Feature:
CRC_16_CHECK_SYNDROME_EN
- Defined: adds output crc_syndrome [15:0]. It equals the received CRC XOR the computed CRC, is captured at DONE and held until the next transaction start, and resets to 0.
- Undefined: port and capture logic are absent. crc_err is unaffected either way.

Decomposition:
- Shared sideband package: CRC16_POLY=16'h8005, CRC16_SEED=16'hFFFF, SYM_BITS=10, START_POS=0, STOP_POS=9, and the FSM state enum (IDLE, DATA, CHECK, DONE, WAIT).
- One natural sub-module: sb_sym_counter, the 0..9 bit counter plus symbol counter with start/stop position strobes. It is reused by the transmit-side CRC block.

Test Plan:
- Payload 0x00 (0,00000000,1), then CRC symbols 0,11111101,1 and 0,00000010,1 -> crc_done pulses once, one cycle after the last stop bit; crc_err=0; frame_err=0.
- Same sequence with the second CRC symbol data bits 00000011 -> crc_done=1, crc_err=1; with CRC_16_CHECK_SYNDROME_EN defined, crc_syndrome=16'h0001.
- Payload stop bit driven 0 -> frame_err=1 and held; a following clean transaction clears it at crc_en rise.
- crc_en dropped after 5 cycles of CHECK -> no crc_done pulse; next clean 0x00 transaction passes with crc_err=0.
- rst asserted mid-DATA -> all outputs 0 immediately, lfsr=16'hFFFF; a subsequent clean transaction passes.
- Zero-length payload with CRC symbols FF and FF (SEED) -> crc_done=1, crc_err=0.
